// File: rtl/ippcrc_crc12_stream_if.sv
// Stream bus for the multi-channel CRC-12 engine: input word framing plus registered result.
// The source holds the master modport; the CRC engine holds the slave modport.
interface ippcrc_crc12_stream_if #(
  parameter int unsigned DW  = 80,
  parameter int unsigned CHW = 2
);
  localparam int unsigned NBW = $clog2(DW / 8) + 1;

  logic           i_vld;
  logic [CHW-1:0] i_ch;
  logic           i_sop;
  logic           i_eop;
  logic [NBW-1:0] i_nbyte;
  logic [DW-1:0]  i_dat;
  logic [11:0]    i_exp;

  logic           o_vld;
  logic [CHW-1:0] o_ch;
  logic [11:0]    o_crc;
  logic           o_err;
  logic           o_seqerr;

  modport master (
    output i_vld, i_ch, i_sop, i_eop, i_nbyte, i_dat, i_exp,
    input  o_vld, o_ch, o_crc, o_err, o_seqerr
  );

  modport slave (
    input  i_vld, i_ch, i_sop, i_eop, i_nbyte, i_dat, i_exp,
    output o_vld, o_ch, o_crc, o_err, o_seqerr
  );
endinterface

// File: rtl/ippcrc_crc12_stream.sv
// Multi-channel streaming CRC-12, one DW-bit word per cycle, one registered result per EOP.
// Define IPPCRC_CRC12_CHECK_EN to build the i_exp comparator driving o_err.
module ippcrc_crc12_stream #(
  parameter int unsigned DW     = 80,
  parameter int unsigned NCH    = 4,
  parameter logic [11:0] POLY   = 12'h80F,
  parameter logic [11:0] INIT   = 12'h000,
  parameter logic [11:0] XOROUT = 12'h000,
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  ippcrc_crc12_stream_if.slave      bus
);

  localparam int unsigned NBYTES = DW / 8;

  logic [11:0]    crc_st_q [NCH];
  logic [11:0]    crc_st_d [NCH];
  logic [NCH-1:0] inpkt_q, inpkt_d;

  logic           o_vld_q, o_vld_d;
  logic [CHW-1:0] o_ch_q, o_ch_d;
  logic [11:0]    o_crc_q, o_crc_d;
  logic           o_err_q, o_err_d;
  logic           o_seqerr_q, o_seqerr_d;

  logic           accept, ch_ok, cur_inpkt, take;
  logic [11:0]    cur_crc, base_crc, next_crc, final_crc;
  int unsigned    nbits;

  // Bit-serial CRC unrolled across the word; bits at or beyond nbits leave the register untouched.
  function automatic logic [11:0] crc_word(input logic [11:0] crc_in, input logic [DW-1:0] dat,
                                           input int unsigned nb);
    logic [11:0] c;
    logic        fb;
    c = crc_in;
    for (int unsigned i = 0; i < DW; i++) begin
      if (i < nb) begin
        fb = c[11] ^ dat[i];
        c  = {c[10:0], 1'b0} ^ (fb ? POLY : 12'h000);
      end
    end
    return c;
  endfunction

  always_comb begin
    accept    = bus.i_vld && !i_clr;
    ch_ok     = 32'(bus.i_ch) < NCH;
    cur_inpkt = 1'b0;
    cur_crc   = INIT;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (CHW'(c) == bus.i_ch) begin
        cur_inpkt = inpkt_q[c];
        cur_crc   = crc_st_q[c];
      end
    end
    take = accept && ch_ok && (bus.i_sop || cur_inpkt);

    // Zero or oversize byte count on EOP means a full word.
    if (!bus.i_eop || bus.i_nbyte == '0 || 32'(bus.i_nbyte) > NBYTES) begin
      nbits = DW;
    end else begin
      nbits = 8 * 32'(bus.i_nbyte);
    end
    base_crc  = bus.i_sop ? INIT : cur_crc;
    next_crc  = crc_word(base_crc, bus.i_dat, nbits);
    final_crc = next_crc ^ XOROUT;
  end

  always_comb begin
    crc_st_d = crc_st_q;
    inpkt_d  = inpkt_q;
    if (i_clr) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        crc_st_d[c] = INIT;
      end
      inpkt_d = '0;
    end else if (take) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (CHW'(c) == bus.i_ch) begin
          crc_st_d[c] = bus.i_eop ? INIT : next_crc;
          inpkt_d[c]  = !bus.i_eop;
        end
      end
    end
  end

  always_comb begin
    o_vld_d    = take && bus.i_eop;
    o_ch_d     = o_vld_d ? bus.i_ch : o_ch_q;
    o_crc_d    = o_vld_d ? final_crc : o_crc_q;
    o_seqerr_d = accept && (!ch_ok || (bus.i_sop == cur_inpkt));
`ifdef IPPCRC_CRC12_CHECK_EN
    o_err_d    = o_vld_d && (final_crc != bus.i_exp);
`else
    o_err_d    = 1'b0;
`endif
  end

`ifndef IPPCRC_CRC12_CHECK_EN
  logic unused_exp;
  assign unused_exp = ^bus.i_exp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        crc_st_q[c] <= INIT;
      end
      inpkt_q    <= '0;
      o_vld_q    <= 1'b0;
      o_ch_q     <= '0;
      o_crc_q    <= 12'h000;
      o_err_q    <= 1'b0;
      o_seqerr_q <= 1'b0;
    end else begin
      crc_st_q   <= crc_st_d;
      inpkt_q    <= inpkt_d;
      o_vld_q    <= o_vld_d;
      o_ch_q     <= o_ch_d;
      o_crc_q    <= o_crc_d;
      o_err_q    <= o_err_d;
      o_seqerr_q <= o_seqerr_d;
    end
  end

  assign bus.o_vld    = o_vld_q;
  assign bus.o_ch     = o_ch_q;
  assign bus.o_crc    = o_crc_q;
  assign bus.o_err    = o_err_q;
  assign bus.o_seqerr = o_seqerr_q;

endmodule

// File: tb/tb_ippcrc_crc12_stream.sv
// Directed bench for ippcrc_crc12_stream (DW=80, NCH=4, POLY=80F, INIT=0, XOROUT=0).
module tb_ippcrc_crc12_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic i_clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ippcrc_crc12_stream_if #(.DW(80), .CHW(2)) bus ();

  ippcrc_crc12_stream #(
    .DW    (80),
    .NCH   (4),
    .POLY  (12'h80F),
    .INIT  (12'h000),
    .XOROUT(12'h000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(i_clr),
    .bus  (bus)
  );

  // Golden bit-serial reference, first bit in time is dat[0].
  function automatic logic [11:0] model(input logic [11:0] crc, input logic [79:0] dat,
                                        input int nb);
    logic [11:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < nb; i++) begin
      fb = c[11] ^ dat[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h80F;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Present one word, then sample the registered outputs 1 time unit after the capturing edge.
  task automatic send(input logic [1:0] ch, input logic sop, input logic eop,
                      input logic [4:0] nbyte, input logic [79:0] dat, input logic [11:0] ex);
    bus.i_vld   = 1'b1;
    bus.i_ch    = ch;
    bus.i_sop   = sop;
    bus.i_eop   = eop;
    bus.i_nbyte = nbyte;
    bus.i_dat   = dat;
    bus.i_exp   = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_vld = 1'b0;
    bus.i_sop = 1'b0;
    bus.i_eop = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [79:0] a1, a2, a3, b1, b2, b3, x;
  logic [11:0] ea, eb, e4;

  initial begin
    a1 = 80'h0123_4567_89AB_CDEF_0F1E;
    a2 = 80'hDEAD_BEEF_CAFE_F00D_1234;
    a3 = 80'h5A5A_A5A5_3C3C_C3C3_9669;
    b1 = 80'hFFFF_0000_FFFF_0000_8001;
    b2 = 80'h1357_9BDF_2468_ACE0_7777;
    b3 = 80'h0000_0000_0000_00AB_CDEF;
    x  = 80'h8421_1248_F0F0_0F0F_AAAA;

    rst_n = 1'b0;
    i_clr = 1'b0;
    bus.i_vld = 1'b0; bus.i_ch = '0; bus.i_sop = 1'b0; bus.i_eop = 1'b0;
    bus.i_nbyte = '0; bus.i_dat = '0; bus.i_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 12'(bus.o_vld), 12'h0);
    chk("rst_ch", 12'(bus.o_ch), 12'h0);
    chk("rst_crc", bus.o_crc, 12'h000);
    chk("rst_seqerr", 12'(bus.o_seqerr), 12'h0);
    rst_n = 1'b1;
    idle();

    // 1: single-byte packet 0x01 -> D05
    send(2'd0, 1'b1, 1'b1, 5'd1, 80'h1, 12'hD05);
    chk("t1_vld", 12'(bus.o_vld), 12'h1);
    chk("t1_ch", 12'(bus.o_ch), 12'h0);
    chk("t1_crc", bus.o_crc, 12'hD05);
    chk("t1_seqerr", 12'(bus.o_seqerr), 12'h0);
    chk("t1_err", 12'(bus.o_err), 12'h0);
    idle();
    chk("t1_vld_pulse", 12'(bus.o_vld), 12'h0);
    chk("t1_crc_hold", bus.o_crc, 12'hD05);

    // 2: zero word then byte 0x01 on ch2; ch0 must still be idle
    send(2'd2, 1'b1, 1'b0, 5'd0, 80'h0, 12'h0);
    chk("t2_sop_vld", 12'(bus.o_vld), 12'h0);
    send(2'd2, 1'b0, 1'b1, 5'd1, 80'h1, 12'h0);
    chk("t2_vld", 12'(bus.o_vld), 12'h1);
    chk("t2_ch", 12'(bus.o_ch), 12'h2);
    chk("t2_crc", bus.o_crc, 12'hD05);
    chk("t2_crc_model", bus.o_crc, model(model(12'h0, 80'h0, 80), 80'h1, 8));
    send(2'd0, 1'b0, 1'b0, 5'd0, 80'h1, 12'h0);
    chk("t2_ch0_idle_seqerr", 12'(bus.o_seqerr), 12'h1);
    chk("t2_ch0_idle_vld", 12'(bus.o_vld), 12'h0);

    // 3: interleaved ch1/ch3, ch3 ends with a 3-byte EOP
    ea = model(model(model(12'h0, a1, 80), a2, 80), a3, 80);
    eb = model(model(model(12'h0, b1, 80), b2, 80), b3, 24);
    send(2'd1, 1'b1, 1'b0, 5'd0, a1, 12'h0);
    send(2'd3, 1'b1, 1'b0, 5'd0, b1, 12'h0);
    send(2'd1, 1'b0, 1'b0, 5'd0, a2, 12'h0);
    send(2'd3, 1'b0, 1'b0, 5'd0, b2, 12'h0);
    chk("t3_mid_seqerr", 12'(bus.o_seqerr), 12'h0);
    send(2'd1, 1'b0, 1'b1, 5'd0, a3, 12'h0);
    chk("t3_a_vld", 12'(bus.o_vld), 12'h1);
    chk("t3_a_ch", 12'(bus.o_ch), 12'h1);
    chk("t3_a_crc", bus.o_crc, ea);
    send(2'd3, 1'b0, 1'b1, 5'd3, b3, 12'h0);
    chk("t3_b_vld", 12'(bus.o_vld), 12'h1);
    chk("t3_b_ch", 12'(bus.o_ch), 12'h3);
    chk("t3_b_crc", bus.o_crc, eb);

    // 4: SOP restart abandons the first packet; stray word on idle ch1 is dropped
    e4 = model(model(12'h0, b2, 80), a1, 40);
    send(2'd0, 1'b1, 1'b0, 5'd0, a2, 12'h0);
    chk("t4_sop1_seqerr", 12'(bus.o_seqerr), 12'h0);
    send(2'd0, 1'b1, 1'b0, 5'd0, b2, 12'h0);
    chk("t4_sop2_seqerr", 12'(bus.o_seqerr), 12'h1);
    chk("t4_sop2_vld", 12'(bus.o_vld), 12'h0);
    send(2'd0, 1'b0, 1'b1, 5'd5, a1, 12'h0);
    chk("t4_eop_seqerr", 12'(bus.o_seqerr), 12'h0);
    chk("t4_eop_vld", 12'(bus.o_vld), 12'h1);
    chk("t4_eop_crc", bus.o_crc, e4);
    send(2'd1, 1'b0, 1'b1, 5'd0, a3, 12'h0);
    chk("t4_stray_seqerr", 12'(bus.o_seqerr), 12'h1);
    chk("t4_stray_vld", 12'(bus.o_vld), 12'h0);
    chk("t4_stray_crc_hold", bus.o_crc, e4);
    idle();
    chk("t4_seqerr_pulse", 12'(bus.o_seqerr), 12'h0);

    // 5: expected-CRC compare
    send(2'd0, 1'b1, 1'b1, 5'd1, 80'h1, 12'hD05);
    chk("t5_match_err", 12'(bus.o_err), 12'h0);
    send(2'd0, 1'b1, 1'b1, 5'd1, 80'h1, 12'hD04);
    chk("t5_vld", 12'(bus.o_vld), 12'h1);
`ifdef IPPCRC_CRC12_CHECK_EN
    chk("t5_mismatch_err", 12'(bus.o_err), 12'h1);
`else
    chk("t5_mismatch_err", 12'(bus.o_err), 12'h0);
`endif

    // Byte-count boundaries: 0 and >DW/8 both mean full word
    send(2'd1, 1'b1, 1'b1, 5'd0, x, 12'h0);
    chk("nb0_crc", bus.o_crc, model(12'h0, x, 80));
    send(2'd1, 1'b1, 1'b1, 5'd15, x, 12'h0);
    chk("nb15_crc", bus.o_crc, model(12'h0, x, 80));
    send(2'd1, 1'b1, 1'b1, 5'd10, x, 12'h0);
    chk("nb10_crc", bus.o_crc, model(12'h0, x, 80));

    // Clear beats a same-cycle EOP and wipes open packets
    send(2'd3, 1'b1, 1'b0, 5'd0, a1, 12'h0);
    i_clr = 1'b1;
    send(2'd3, 1'b0, 1'b1, 5'd0, a2, 12'h0);
    i_clr = 1'b0;
    chk("clr_vld", 12'(bus.o_vld), 12'h0);
    chk("clr_seqerr", 12'(bus.o_seqerr), 12'h0);
    send(2'd3, 1'b0, 1'b1, 5'd0, a2, 12'h0);
    chk("clr_after_seqerr", 12'(bus.o_seqerr), 12'h1);
    chk("clr_after_vld", 12'(bus.o_vld), 12'h0);

    // 6: asynchronous reset mid-packet
    send(2'd0, 1'b1, 1'b0, 5'd0, a3, 12'h0);
    send(2'd2, 1'b1, 1'b1, 5'd1, 80'h1, 12'h0);
    chk("t6_pre_vld", 12'(bus.o_vld), 12'h1);
    bus.i_vld = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_vld", 12'(bus.o_vld), 12'h0);
    chk("t6_rst_ch", 12'(bus.o_ch), 12'h0);
    chk("t6_rst_crc", bus.o_crc, 12'h000);
    chk("t6_rst_err", 12'(bus.o_err), 12'h0);
    chk("t6_rst_seqerr", 12'(bus.o_seqerr), 12'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(2'd0, 1'b0, 1'b1, 5'd1, 80'h0, 12'h0);
    chk("t6_discard_seqerr", 12'(bus.o_seqerr), 12'h1);
    chk("t6_discard_vld", 12'(bus.o_vld), 12'h0);
    send(2'd0, 1'b1, 1'b1, 5'd1, 80'h0, 12'h0);
    chk("t6_zero_vld", 12'(bus.o_vld), 12'h1);
    chk("t6_zero_crc", bus.o_crc, 12'h000);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
